ddr_init_seq: RTL and testbench
===============================

DDR_INIT_SEQ -- requirements
Module: ddr_init_seq

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 26600, giving the clock-stable wait before CKE rises (200 us at 133 MHz).
REQ-002 SHALL have parameter DLL_CYCLES, default 200, giving the minimum cycles from the DLL-reset MRS to initDone.
REQ-003 SHALL have parameter T_RP, default 3, giving the precharge slot length in cycles.
REQ-004 SHALL have parameter T_MRD, default 2, giving the mode-register slot length in cycles.
REQ-005 SHALL have parameter T_RFC, default 10, giving the auto-refresh slot length in cycles.
REQ-006 SHALL have parameter MODE_REG, default 13'h061 (BL=2, sequential, CL=2.5).
REQ-007 SHALL have port clk, input, 1 bit: the 133 MHz DDR clock (clk133_p domain); this is the only clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset (asserted while clocks are unlocked).
REQ-009 SHALL have port cke, output, 1 bit: SDRAM clock enable.
REQ-010 SHALL have port cmd, output, 4 bits: {cs_n, ras_n, cas_n, we_n}.
REQ-011 SHALL have port ba, output, 2 bits: bank address.
REQ-012 SHALL have port addr, output, 13 bits: row/mode address.
REQ-013 SHALL have port initDone, output, 1 bit: high once the SDRAM is ready for normal commands.

Function
REQ-014 SHALL use these command encodings: NOP=0111, PRECHARGE=0010, AUTO_REFRESH=0001, LOAD_MODE=0000, DESELECT=1111.
REQ-015 SHALL drive all outputs from registers; there SHALL be no combinational path from any input to any output.
REQ-016 SHALL step through the states WAIT_STABLE, CKE_NOP, PRE1, EMRS, MRS_DLL, PRE2, AREF1, AREF2, MRS, DLL_WAIT, DONE, in that order.
REQ-017 SHALL, in WAIT_STABLE, hold cke=0 and cmd=DESELECT for WAIT_CYCLES cycles after reset release, then raise cke.
REQ-018 SHALL, in CKE_NOP, issue NOP for 2 cycles.
REQ-019 SHALL drive each command in a single cycle, the first cycle of its state.
REQ-020 SHALL drive NOP for the remaining cycles of each command state; state length is T_RP for PRE*, T_MRD for EMRS/MRS*, T_RFC for AREF*.
REQ-021 SHALL drive addr[10]=1 (precharge all) for PRE1 and PRE2.
REQ-022 SHALL, in EMRS, drive ba=01 and addr=0 (DLL enable, normal drive).
REQ-023 SHALL, in MRS_DLL, drive ba=00 and addr=MODE_REG|13'h100 (DLL reset).
REQ-024 SHALL, in MRS, drive ba=00 and addr=MODE_REG.
REQ-025 SHALL hold ba=0 and addr=0 on every NOP or DESELECT cycle.
REQ-026 SHALL start a DLL counter on the cycle MRS_DLL is issued.
REQ-027 SHALL, in DLL_WAIT, issue NOP until the DLL counter reaches DLL_CYCLES.
REQ-028 SHALL enter DONE in the cycle after the DLL counter reaches DLL_CYCLES, or immediately after MRS if the count is already reached.
REQ-029 SHALL, in DONE, hold initDone=1, cke=1 and cmd=NOP indefinitely; DONE is terminal except on reset.
REQ-030 SHALL size its counters at $clog2 of the largest parameter plus 1, and counters SHALL saturate, never wrap.

Reset
REQ-031 SHALL, while rst=1, immediately force state=WAIT_STABLE, cke=0, cmd=DESELECT, ba=0, addr=0, initDone=0, and clear all counters.
REQ-032 SHALL, on rst asserted mid-sequence (including in DONE), abort and repeat the full sequence including the WAIT_CYCLES wait.

Structure
REQ-033 SHALL take command encodings, the state enumeration and the mode-register bit constants (DLL-reset bit 8, A10) from shared package ddr_pkg.
REQ-034 SHALL instantiate one sub-module, ddr_gap_timer, a loadable saturating down-counter reused for the wait and gap timing.

Verification
REQ-035 SHALL verify: WAIT_CYCLES=10, DLL_CYCLES=200, release rst -> cke rises at cycle 10; PRE at 12, EMRS at 15, MRS_DLL at 17 with addr=0x161.
REQ-036 SHALL verify: the same run -> PRE at 19, AREF at 22 and 32, MRS at 42 with addr=0x061, initDone=1 at cycle 217.
REQ-037 SHALL verify: DLL_CYCLES=5 -> initDone at cycle 44, immediately after the MRS slot.
REQ-038 SHALL verify: rst pulsed at cycle 25 (inside AREF1) -> cke=0 and cmd=1111 the same cycle; the sequence restarts and cke rises 10 cycles after release.
REQ-039 SHALL verify: rst pulsed after initDone -> initDone=0 asynchronously, then full sequence repeats with identical timing.
REQ-040 SHALL verify: assertion across all runs -> no command other than NOP/DESELECT while cke=0, and ba=addr=0 on every NOP.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR SDRAM power-up initialisation sequencer.
package ddr_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned BA_W   = 2;
    localparam int unsigned ADDR_W = 13;

    // Mode-register address bits with special meaning during init.
    localparam int unsigned MR_DLL_RESET_BIT = 8;
    localparam int unsigned ADDR_A10_BIT     = 10;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [CMD_W-1:0] {
        CMD_LOAD_MODE    = 4'b0000,
        CMD_AUTO_REFRESH = 4'b0001,
        CMD_PRECHARGE    = 4'b0010,
        CMD_NOP          = 4'b0111,
        CMD_DESELECT     = 4'b1111
    } ddr_cmd_e;

    typedef enum logic [3:0] {
        ST_WAIT_STABLE,
        ST_CKE_NOP,
        ST_PRE1,
        ST_EMRS,
        ST_MRS_DLL,
        ST_PRE2,
        ST_AREF1,
        ST_AREF2,
        ST_MRS,
        ST_DLL_WAIT,
        ST_DONE
    } init_state_e;

    // Everything the sequencer drives toward the SDRAM pins.
    typedef struct packed {
        logic              cke;
        ddr_cmd_e          cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
        logic              init_done;
    } ddr_bus_t;

    localparam ddr_bus_t BUS_RESET = '{
        cke:       1'b0,
        cmd:       CMD_DESELECT,
        ba:        '0,
        addr:      '0,
        init_done: 1'b0
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_gap_timer.sv
// Loadable saturating down-counter used for the stable-clock wait and command gaps.
module ddr_gap_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register, cleared while reset is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/ddr_init_seq.sv
// DDR SDRAM power-up initialisation sequencer: stable-clock wait, CKE, precharge,
// EMRS/MRS programming, two auto-refreshes and the DLL lock wait.
module ddr_init_seq
    import ddr_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 26600,
    parameter int unsigned DLL_CYCLES  = 200,
    parameter int unsigned T_RP        = 3,
    parameter int unsigned T_MRD       = 2,
    parameter int unsigned T_RFC       = 10,
    parameter logic [12:0] MODE_REG    = 13'h061
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cke,
    output logic [3:0]  cmd,
    output logic [1:0]  ba,
    output logic [12:0] addr,
    output logic        initDone
);

    localparam int unsigned MAX_P = max_u(max_u(max_u(WAIT_CYCLES, DLL_CYCLES),
                                                max_u(T_RP, T_MRD)), T_RFC);
    localparam int unsigned CW    = $clog2(MAX_P) + 1;

    // Timer reload values: a slot of N cycles loads N-1 and ends when the timer hits 0.
    // The wait loads two less because its first cycle is spent arming the timer.
    localparam logic [CW-1:0] LD_WAIT    = CW'((WAIT_CYCLES >= 2) ? (WAIT_CYCLES - 2) : 0);
    localparam logic [CW-1:0] LD_CKE_NOP = CW'(1);
    localparam logic [CW-1:0] LD_RP      = CW'((T_RP  >= 1) ? (T_RP  - 1) : 0);
    localparam logic [CW-1:0] LD_MRD     = CW'((T_MRD >= 1) ? (T_MRD - 1) : 0);
    localparam logic [CW-1:0] LD_RFC     = CW'((T_RFC >= 1) ? (T_RFC - 1) : 0);
    localparam logic [CW-1:0] DLL_TARGET = CW'(DLL_CYCLES);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    localparam logic [ADDR_W-1:0] ADDR_A10     = ADDR_W'(1) << ADDR_A10_BIT;
    localparam logic [ADDR_W-1:0] ADDR_MRS_DLL = MODE_REG | (ADDR_W'(1) << MR_DLL_RESET_BIT);

    init_state_e   state_q, state_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] dll_cnt_q, dll_cnt_d;
    logic          dll_run_q, dll_run_d;
    ddr_bus_t      bus_q, bus_d;

    logic          gap_load;
    logic [CW-1:0] gap_load_val;
    logic [CW-1:0] gap_cnt;
    logic          gap_zero;
    logic          dll_reached;
    logic          entering;

    // Slot length (minus one) of each timed state.
    function automatic logic [CW-1:0] slot_load(input init_state_e s);
        case (s)
            ST_CKE_NOP:                   return LD_CKE_NOP;
            ST_PRE1, ST_PRE2:             return LD_RP;
            ST_EMRS, ST_MRS_DLL, ST_MRS:  return LD_MRD;
            ST_AREF1, ST_AREF2:           return LD_RFC;
            default:                      return '0;
        endcase
    endfunction

    ddr_gap_timer #(
        .W (CW)
    ) u_gap_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .count_o    (gap_cnt)
    );

    assign gap_zero    = (gap_cnt == '0);
    assign dll_reached = (dll_cnt_q >= DLL_TARGET);

    // Next state, timer control, DLL counter and the pin values for the next cycle.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        dll_run_d    = dll_run_q;
        dll_cnt_d    = (dll_run_q && (dll_cnt_q != CNT_MAX)) ? (dll_cnt_q + CW'(1)) : dll_cnt_q;
        gap_load     = 1'b0;
        gap_load_val = '0;
        bus_d        = BUS_RESET;

        case (state_q)
            ST_WAIT_STABLE: begin
                if (!armed_q) begin
                    armed_d = 1'b1;
                    if (WAIT_CYCLES <= 1) begin
                        state_d = ST_CKE_NOP;
                    end
                end else if (gap_zero) begin
                    state_d = ST_CKE_NOP;
                end
            end
            ST_CKE_NOP:  if (gap_zero) state_d = ST_PRE1;
            ST_PRE1:     if (gap_zero) state_d = ST_EMRS;
            ST_EMRS:     if (gap_zero) state_d = ST_MRS_DLL;
            ST_MRS_DLL:  if (gap_zero) state_d = ST_PRE2;
            ST_PRE2:     if (gap_zero) state_d = ST_AREF1;
            ST_AREF1:    if (gap_zero) state_d = ST_AREF2;
            ST_AREF2:    if (gap_zero) state_d = ST_MRS;
            ST_MRS:      if (gap_zero) state_d = dll_reached ? ST_DONE : ST_DLL_WAIT;
            ST_DLL_WAIT: if (dll_reached) state_d = ST_DONE;
            ST_DONE:     state_d = ST_DONE;
            default:     state_d = ST_WAIT_STABLE;
        endcase

        entering = (state_d != state_q);

        if (entering) begin
            gap_load     = 1'b1;
            gap_load_val = slot_load(state_d);
        end else if ((state_q == ST_WAIT_STABLE) && !armed_q) begin
            gap_load     = 1'b1;
            gap_load_val = LD_WAIT;
        end

        // The DLL lock window opens on the cycle the DLL-reset MRS is on the bus.
        if (entering && (state_d == ST_MRS_DLL)) begin
            dll_cnt_d = CW'(1);
            dll_run_d = 1'b1;
        end

        bus_d.cke       = (state_d != ST_WAIT_STABLE);
        bus_d.cmd       = (state_d == ST_WAIT_STABLE) ? CMD_DESELECT : CMD_NOP;
        bus_d.init_done = (state_d == ST_DONE);

        // A command occupies only the first cycle of its slot.
        if (entering) begin
            case (state_d)
                ST_PRE1, ST_PRE2: begin
                    bus_d.cmd  = CMD_PRECHARGE;
                    bus_d.addr = ADDR_A10;
                end
                ST_EMRS: begin
                    bus_d.cmd = CMD_LOAD_MODE;
                    bus_d.ba  = BA_W'(1);
                end
                ST_MRS_DLL: begin
                    bus_d.cmd  = CMD_LOAD_MODE;
                    bus_d.addr = ADDR_MRS_DLL;
                end
                ST_AREF1, ST_AREF2: begin
                    bus_d.cmd = CMD_AUTO_REFRESH;
                end
                ST_MRS: begin
                    bus_d.cmd  = CMD_LOAD_MODE;
                    bus_d.addr = MODE_REG;
                end
                default: ;
            endcase
        end
    end

    // State, counters and registered pin drivers; reset aborts the sequence at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_STABLE;
            armed_q   <= 1'b0;
            dll_cnt_q <= '0;
            dll_run_q <= 1'b0;
            bus_q     <= BUS_RESET;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            dll_cnt_q <= dll_cnt_d;
            dll_run_q <= dll_run_d;
            bus_q     <= bus_d;
        end
    end

    assign cke      = bus_q.cke;
    assign cmd      = bus_q.cmd;
    assign ba       = bus_q.ba;
    assign addr     = bus_q.addr;
    assign initDone = bus_q.init_done;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Bench for ddr_init_seq: two instances (long and short DLL wait) share clock and reset;
// expected command events are queued at each reset release and matched as they appear.
module tb_ddr_init_seq;

    typedef enum int {EV_CKE, EV_CMD, EV_DONE} ev_kind_e;

    typedef struct {
        ev_kind_e    kind;
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        cke_a, cke_b;
    logic [3:0]  cmd_a, cmd_b;
    logic [1:0]  ba_a, ba_b;
    logic [12:0] addr_a, addr_b;
    logic        done_a, done_b;

    ev_t qa[$];
    ev_t qb[$];
    int  cyc;
    int  checks   = 0;
    int  failures = 0;
    logic pcke [2];
    logic pdone [2];

    ddr_init_seq #(
        .WAIT_CYCLES (10),
        .DLL_CYCLES  (200)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .cke      (cke_a),
        .cmd      (cmd_a),
        .ba       (ba_a),
        .addr     (addr_a),
        .initDone (done_a)
    );

    ddr_init_seq #(
        .WAIT_CYCLES (10),
        .DLL_CYCLES  (5)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .cke      (cke_b),
        .cmd      (cmd_b),
        .ba       (ba_b),
        .addr     (addr_b),
        .initDone (done_b)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset release.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t mk(input ev_kind_e k, input int c, input logic [3:0] cm,
                               input logic [1:0] b, input logic [12:0] a);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cmd  = cm;
        e.ba   = b;
        e.addr = a;
        return e;
    endfunction

    task automatic push2(input ev_t e);
        qa.push_back(e);
        qb.push_back(e);
    endtask

    // Expected timeline with WAIT_CYCLES=10 and default slot lengths.
    task automatic push_run();
        push2(mk(EV_CKE, 10, 4'b0111, 2'b00, 13'h000));
        push2(mk(EV_CMD, 12, 4'b0010, 2'b00, 13'h400));
        push2(mk(EV_CMD, 15, 4'b0000, 2'b01, 13'h000));
        push2(mk(EV_CMD, 17, 4'b0000, 2'b00, 13'h161));
        push2(mk(EV_CMD, 19, 4'b0010, 2'b00, 13'h400));
        push2(mk(EV_CMD, 22, 4'b0001, 2'b00, 13'h000));
        push2(mk(EV_CMD, 32, 4'b0001, 2'b00, 13'h000));
        push2(mk(EV_CMD, 42, 4'b0000, 2'b00, 13'h061));
        qa.push_back(mk(EV_DONE, 217, 4'b0111, 2'b00, 13'h000));
        qb.push_back(mk(EV_DONE, 44, 4'b0111, 2'b00, 13'h000));
    endtask

    task automatic expect_ev(input int id, input ev_kind_e k, input logic [3:0] cm,
                             input logic [1:0] b, input logic [12:0] a);
        ev_t   e;
        string nm = (id == 0) ? "a" : "b";
        int    sz = (id == 0) ? qa.size() : qb.size();
        check($sformatf("%s_ev_pending_c%0d", nm, cyc), 32'(sz != 0), 32'd1);
        if (sz == 0) return;
        if (id == 0) e = qa.pop_front();
        else         e = qb.pop_front();
        check($sformatf("%s_ev_kind_c%0d", nm, cyc), 32'(k), 32'(e.kind));
        check($sformatf("%s_ev_cycle_k%0d", nm, int'(k)), 32'(cyc), 32'(e.cyc));
        if (k == EV_CMD) begin
            check($sformatf("%s_cmd_c%0d", nm, cyc), 32'(cm), 32'(e.cmd));
            check($sformatf("%s_ba_c%0d", nm, cyc), 32'(b), 32'(e.ba));
            check($sformatf("%s_addr_c%0d", nm, cyc), 32'(a), 32'(e.addr));
        end
    endtask

    task automatic observe(input int id, input logic ck, input logic [3:0] cm,
                           input logic [1:0] b, input logic [12:0] a, input logic dn);
        string nm   = (id == 0) ? "a" : "b";
        logic  idle = (cm == 4'b0111) || (cm == 4'b1111);
        if (!ck) check($sformatf("%s_cmd_while_cke0_c%0d", nm, cyc), 32'(idle), 32'd1);
        if (idle) check($sformatf("%s_idle_ba_addr_c%0d", nm, cyc), 32'({b, a}), 32'd0);
        if (pdone[id]) check($sformatf("%s_done_hold_c%0d", nm, cyc), 32'(dn), 32'd1);
        if (ck && !pcke[id]) expect_ev(id, EV_CKE, cm, b, a);
        if (!idle) expect_ev(id, EV_CMD, cm, b, a);
        if (dn && !pdone[id]) expect_ev(id, EV_DONE, cm, b, a);
        if (dn) begin
            check($sformatf("%s_done_cmd_c%0d", nm, cyc), 32'(cm), 32'h7);
            check($sformatf("%s_done_cke_c%0d", nm, cyc), 32'(ck), 32'd1);
        end
        pcke[id]  = ck;
        pdone[id] = dn;
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pcke[0] = 1'b0; pcke[1] = 1'b0;
            pdone[0] = 1'b0; pdone[1] = 1'b0;
        end else begin
            observe(0, cke_a, cmd_a, ba_a, addr_a, done_a);
            observe(1, cke_b, cmd_b, ba_b, addr_b, done_b);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_cke"},  32'(cke_a), 32'd0);
        check({tag, "_a_cmd"},  32'(cmd_a), 32'hF);
        check({tag, "_a_baad"}, 32'({ba_a, addr_a}), 32'd0);
        check({tag, "_a_done"}, 32'(done_a), 32'd0);
        check({tag, "_b_cke"},  32'(cke_b), 32'd0);
        check({tag, "_b_cmd"},  32'(cmd_b), 32'hF);
        check({tag, "_b_baad"}, 32'({ba_b, addr_b}), 32'd0);
        check({tag, "_b_done"}, 32'(done_b), 32'd0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_run();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (((qa.size() + qb.size()) != 0) && (n < budget)) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_drain_left"}, 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic check_done_hold(input string tag);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_a_done"}, 32'(done_a), 32'd1);
        check({tag, "_a_cmd"},  32'(cmd_a), 32'h7);
        check({tag, "_a_cke"},  32'(cke_a), 32'd1);
        check({tag, "_b_done"}, 32'(done_b), 32'd1);
        check({tag, "_b_cmd"},  32'(cmd_b), 32'h7);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst0");

        // Full sequence from power-up.
        release_rst();
        wait_drain("run1", 300);
        check_done_hold("run1_hold");

        // Reset after initDone clears the outputs without waiting for a clock.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_done");
        repeat (2) @(posedge clk);

        // Repeat must have identical timing.
        release_rst();
        wait_drain("run2", 300);
        check_done_hold("run2_hold");

        // Abort inside AREF1.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        release_rst();
        n = 0;
        while ((cyc != 25) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("mid_reach_c25", 32'(cyc), 32'd25);
        check("mid_a_cmd_c25", 32'(cmd_a), 32'h7);
        check("mid_a_cke_c25", 32'(cke_a), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        check("mid_a_left", 32'(qa.size()), 32'd3);
        check("mid_b_left", 32'(qb.size()), 32'd3);
        qa.delete();
        qb.delete();
        repeat (3) @(posedge clk);

        // Restart after the abort runs the whole sequence again.
        release_rst();
        wait_drain("run3", 300);
        check_done_hold("run3_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
